// File: rtl/keccak_lane_if.sv
// Lane-stream bundle between a block source, the lane transmitter and the
// serial-in state loader.
interface keccak_lane_if #(
   parameter int LANE_W    = 64,
   parameter int NUM_LANES = 25,
   parameter int IDX_W     = 5
);
   logic [LANE_W*NUM_LANES-1:0] blk_in;
   logic                        blk_valid;
   logic                        blk_ready;
   logic [LANE_W-1:0]           lane_out;
   logic                        lane_valid;
   logic                        lane_ready;
   logic [IDX_W-1:0]            lane_idx;
   logic                        lane_first;
   logic                        lane_last;
   logic                        busy;

   modport master (
      input  blk_in, blk_valid, lane_ready,
      output blk_ready, lane_out, lane_valid, lane_idx, lane_first, lane_last, busy
   );

   modport slave (
      output blk_in, blk_valid, lane_ready,
      input  blk_ready, lane_out, lane_valid, lane_idx, lane_first, lane_last, busy
   );
endinterface

// File: rtl/keccak_lane_tx.sv
// Lane transmitter: captures a 1600-bit block and streams it as 25 lanes,
// lane 0 first, then holds an idle gap while the permutation runs.
module keccak_lane_tx #(
   parameter int LANE_W     = 64,
   parameter int NUM_LANES  = 25,
   parameter int IDX_W      = 5,
   parameter int GAP_CYCLES = 24
) (
   input  logic          clk,
   input  logic          rst,
   keccak_lane_if.master bus
);
   localparam int BLK_W = LANE_W * NUM_LANES;
   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [BLK_W-1:0]  shreg_r;
   logic [IDX_W-1:0]  lane_cnt_r;
   logic [GAP_W-1:0]  gap_cnt_r;
   logic              blk_fire_s;
   logic              lane_fire_s;
   logic              last_fire_s;
   logic              send_s;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and handshake strobes.
   always_comb begin
      state_s     = state_r;
      blk_fire_s  = 1'b0;
      lane_fire_s = 1'b0;
      last_fire_s = 1'b0;
      case (state_r)
         IDLE: begin
            blk_fire_s = bus.blk_valid & ~rst;
            if (blk_fire_s) begin
               state_s = SEND;
            end else begin
               state_s = IDLE;
            end
         end
         SEND: begin
            lane_fire_s = bus.lane_ready;
            last_fire_s = bus.lane_ready & (lane_cnt_r == LAST_IDX);
            if (last_fire_s) begin
               // A zero gap returns straight to IDLE so blocks run back to back.
               if (GAP_CYCLES == 0) begin
                  state_s = IDLE;
               end else begin
                  state_s = GAP;
               end
            end else begin
               state_s = SEND;
            end
         end
         GAP: begin
            if (gap_cnt_r <= GAP_W'(1)) begin
               state_s = IDLE;
            end else begin
               state_s = GAP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Block shift register and lane counter; the low lane is always the one on the wire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_r    <= {BLK_W{1'b0}};
         lane_cnt_r <= {IDX_W{1'b0}};
      end else if (blk_fire_s) begin
         shreg_r    <= bus.blk_in;
         lane_cnt_r <= {IDX_W{1'b0}};
      end else if (lane_fire_s) begin
         shreg_r <= shreg_r >> LANE_W;
         if (last_fire_s) begin
            lane_cnt_r <= {IDX_W{1'b0}};
         end else begin
            lane_cnt_r <= lane_cnt_r + IDX_W'(1);
         end
      end else begin
         shreg_r    <= shreg_r;
         lane_cnt_r <= lane_cnt_r;
      end
   end

   // Idle-gap down-counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt_r <= {GAP_W{1'b0}};
      end else if (last_fire_s) begin
         gap_cnt_r <= GAP_LOAD;
      end else if ((state_r == GAP) && (gap_cnt_r != {GAP_W{1'b0}})) begin
         gap_cnt_r <= gap_cnt_r - GAP_W'(1);
      end else begin
         gap_cnt_r <= gap_cnt_r;
      end
   end

   assign send_s         = (state_r == SEND);
   assign bus.blk_ready  = (state_r == IDLE) & ~rst;
   assign bus.lane_valid = send_s;
   assign bus.lane_out   = send_s ? shreg_r[LANE_W-1:0] : {LANE_W{1'b0}};
   assign bus.lane_idx   = lane_cnt_r;
   assign bus.lane_first = send_s & (lane_cnt_r == {IDX_W{1'b0}});
   assign bus.lane_last  = send_s & (lane_cnt_r == LAST_IDX);
   assign bus.busy       = (state_r != IDLE);

endmodule

// File: tb/tb_keccak_lane_tx.sv
// Directed bench for keccak_lane_tx: a 24-cycle-gap instance and a zero-gap instance.
module tb_keccak_lane_tx;
   localparam int LANE_W    = 64;
   localparam int NUM_LANES = 25;
   localparam int IDX_W     = 5;
   localparam int BLK_W     = LANE_W * NUM_LANES;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   keccak_lane_if #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) a ();
   keccak_lane_if #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W)) b ();

   keccak_lane_tx #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W), .GAP_CYCLES(24)) dut (
      .clk (clk),
      .rst (rst),
      .bus (a)
   );

   keccak_lane_tx #(.LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .IDX_W(IDX_W), .GAP_CYCLES(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (b)
   );

   always #5 clk = ~clk;

   function automatic logic [BLK_W-1:0] mk_blk(input logic [63:0] base);
      logic [BLK_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_LANES; i++) v[LANE_W*i +: LANE_W] = base + 64'(i);
      return v;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (a.lane_valid !== 1'b0 || a.lane_out !== 64'h0 || a.lane_idx !== 5'd0 || a.lane_first !== 1'b0 ||
          a.lane_last !== 1'b0 || a.busy !== 1'b0 || a.blk_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs actual v=%0b d=%h idx=%0d f=%0b l=%0b busy=%0b rdy=%0b required all 0",
                  a.lane_valid, a.lane_out, a.lane_idx, a.lane_first, a.lane_last, a.busy, a.blk_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (a.blk_ready !== 1'b1 || b.blk_ready !== 1'b1 || a.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release actual rdy=%0b rdy0=%0b busy=%0b required 1 1 0", a.blk_ready, b.blk_ready, a.busy);
      end
   endtask

   task automatic test_stream();
      int gap;
      @(negedge clk);
      a.blk_in = mk_blk(64'h1000); a.blk_valid = 1'b1; a.lane_ready = 1'b1;
      checks++;
      if (a.blk_ready !== 1'b1) begin
         errors++; $display("FAIL stream_blk_ready actual=%0b required=1", a.blk_ready);
      end
      for (int k = 0; k < NUM_LANES; k++) begin
         @(negedge clk);
         a.blk_valid = 1'b0;
         checks++;
         if (a.lane_valid !== 1'b1 || a.lane_out !== 64'h1000 + 64'(k) || a.lane_idx !== IDX_W'(k) ||
             a.lane_first !== ((k == 0) ? 1'b1 : 1'b0) || a.lane_last !== ((k == NUM_LANES-1) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL stream_lane k=%0d actual v=%0b d=%h idx=%0d f=%0b l=%0b required d=%h",
                     k, a.lane_valid, a.lane_out, a.lane_idx, a.lane_first, a.lane_last, 64'h1000 + 64'(k));
         end
      end
      gap = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (a.blk_ready === 1'b1) break;
         gap++;
         if (a.lane_valid !== 1'b0 || a.lane_out !== 64'h0 || a.busy !== 1'b1) begin
            errors++; checks++;
            $display("FAIL stream_gap_state c=%0d actual v=%0b d=%h busy=%0b required 0 0 1", c, a.lane_valid, a.lane_out, a.busy);
         end
      end
      checks++;
      if (gap !== 24) begin
         errors++; $display("FAIL stream_gap_len actual=%0d required=24", gap);
      end
   endtask

   task automatic test_backpressure();
      int e, vc, stall, held7;
      @(negedge clk);
      a.blk_in = mk_blk(64'h1000); a.blk_valid = 1'b1; a.lane_ready = 1'b1;
      e = 0; vc = 0; stall = 3; held7 = 0;
      for (int c = 0; c < 100 && e < NUM_LANES; c++) begin
         @(negedge clk);
         a.blk_valid = 1'b0;
         if (a.lane_valid === 1'b1) begin
            vc++;
            checks++;
            if (a.lane_out !== 64'h1000 + 64'(e) || a.lane_idx !== IDX_W'(e)) begin
               errors++;
               $display("FAIL bp_lane actual d=%h idx=%0d required d=%h idx=%0d", a.lane_out, a.lane_idx, 64'h1000 + 64'(e), e);
            end
            if (e == 7) held7++;
            if (e == 7 && stall > 0) begin
               a.lane_ready = 1'b0; stall--;
            end else begin
               a.lane_ready = 1'b1; e++;
            end
         end else begin
            a.lane_ready = 1'b1;
         end
      end
      a.lane_ready = 1'b1;
      checks++;
      if (e !== 25 || vc !== 28 || held7 !== 4) begin
         errors++; $display("FAIL bp_counts actual lanes=%0d valid=%0d held7=%0d required 25 28 4", e, vc, held7);
      end
      for (int c = 0; c < 60; c++) begin
         if (a.blk_ready === 1'b1) break;
         @(negedge clk);
      end
      checks++;
      if (a.blk_ready !== 1'b1) begin
         errors++; $display("FAIL bp_ready_return actual=%0b required=1", a.blk_ready);
      end
   endtask

   task automatic test_back_to_back();
      int bk, e, idle, gapbusy;
      @(negedge clk);
      a.blk_in = mk_blk(64'h1000); a.blk_valid = 1'b1; a.lane_ready = 1'b1;
      bk = 0; e = 0; idle = 0; gapbusy = 0;
      for (int c = 0; c < 200 && bk < 2; c++) begin
         @(negedge clk);
         if (a.lane_valid === 1'b1) begin
            checks++;
            if (a.lane_out !== ((bk == 0) ? 64'h1000 : 64'h2000) + 64'(e)) begin
               errors++; $display("FAIL b2b_lane blk=%0d e=%0d actual=%h", bk, e, a.lane_out);
            end
            if (bk == 0 && e == 0) a.blk_in = mk_blk(64'h2000);
            if (bk == 1) a.blk_valid = 1'b0;
            e++;
            if (e == NUM_LANES) begin bk++; e = 0; end
         end else if (bk == 1 && e == 0) begin
            if (a.busy === 1'b1) gapbusy++;
            else idle++;
         end
      end
      a.blk_valid = 1'b0;
      checks++;
      if (bk !== 2 || gapbusy !== 24 || idle !== 1) begin
         errors++; $display("FAIL b2b_gap actual blocks=%0d gap=%0d idle=%0d required 2 24 1", bk, gapbusy, idle);
      end
      for (int c = 0; c < 60; c++) begin
         if (a.blk_ready === 1'b1) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset_mid();
      int found;
      @(negedge clk);
      a.blk_in = mk_blk(64'h3000); a.blk_valid = 1'b1; a.lane_ready = 1'b1;
      found = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         a.blk_valid = 1'b0;
         if (a.lane_valid === 1'b1 && a.lane_idx === 5'd12) begin found = 1; break; end
      end
      checks++;
      if (found !== 1) begin
         errors++; $display("FAIL rst_mid_reach actual=%0d required=1", found);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (a.lane_valid !== 1'b0 || a.lane_out !== 64'h0 || a.lane_idx !== 5'd0 || a.lane_first !== 1'b0 ||
          a.lane_last !== 1'b0 || a.busy !== 1'b0 || a.blk_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_async actual v=%0b d=%h idx=%0d busy=%0b rdy=%0b required all 0",
                  a.lane_valid, a.lane_out, a.lane_idx, a.busy, a.blk_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (a.blk_ready !== 1'b1 || a.busy !== 1'b0 || a.lane_valid !== 1'b0) begin
         errors++; $display("FAIL rst_mid_release actual rdy=%0b busy=%0b v=%0b required 1 0 0", a.blk_ready, a.busy, a.lane_valid);
      end
      a.blk_in = mk_blk(64'h4000); a.blk_valid = 1'b1;
      for (int k = 0; k < NUM_LANES; k++) begin
         @(negedge clk);
         a.blk_valid = 1'b0;
         checks++;
         if (a.lane_valid !== 1'b1 || a.lane_out !== 64'h4000 + 64'(k) || a.lane_idx !== IDX_W'(k)) begin
            errors++;
            $display("FAIL rst_mid_restart k=%0d actual v=%0b d=%h idx=%0d", k, a.lane_valid, a.lane_out, a.lane_idx);
         end
      end
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (a.blk_ready === 1'b1) break;
      end
   endtask

   task automatic test_zero_gap();
      int bk, e, idle, gapbusy, rdy_seen;
      @(negedge clk);
      b.blk_in = mk_blk(64'h5000); b.blk_valid = 1'b1; b.lane_ready = 1'b1;
      bk = 0; e = 0; idle = 0; gapbusy = 0; rdy_seen = 0;
      for (int c = 0; c < 200 && bk < 2; c++) begin
         @(negedge clk);
         if (b.lane_valid === 1'b1) begin
            checks++;
            if (b.lane_out !== ((bk == 0) ? 64'h5000 : 64'h6000) + 64'(e) || b.lane_idx !== IDX_W'(e)) begin
               errors++; $display("FAIL zgap_lane blk=%0d e=%0d actual d=%h idx=%0d", bk, e, b.lane_out, b.lane_idx);
            end
            if (bk == 0 && e == 0) b.blk_in = mk_blk(64'h6000);
            if (bk == 1) b.blk_valid = 1'b0;
            e++;
            if (e == NUM_LANES) begin bk++; e = 0; end
         end else if (bk == 1 && e == 0) begin
            if (b.busy === 1'b1) gapbusy++;
            else idle++;
            if (b.blk_ready === 1'b1) rdy_seen++;
         end
      end
      b.blk_valid = 1'b0;
      checks++;
      if (bk !== 2 || gapbusy !== 0 || idle !== 1 || rdy_seen !== 1) begin
         errors++;
         $display("FAIL zgap_sep actual blocks=%0d gap=%0d idle=%0d rdy=%0d required 2 0 1 1", bk, gapbusy, idle, rdy_seen);
      end
   endtask

   task automatic test_ignore_busy();
      @(negedge clk);
      a.blk_in = mk_blk(64'h7000); a.blk_valid = 1'b1; a.lane_ready = 1'b1;
      for (int k = 0; k < NUM_LANES; k++) begin
         @(negedge clk);
         a.blk_valid = (k == 10) ? 1'b1 : 1'b0;
         if (k == 10) a.blk_in = mk_blk(64'h8000);
         checks++;
         if (a.lane_valid !== 1'b1 || a.lane_out !== 64'h7000 + 64'(k) || a.lane_idx !== IDX_W'(k)) begin
            errors++;
            $display("FAIL ignore_lane k=%0d actual v=%0b d=%h idx=%0d", k, a.lane_valid, a.lane_out, a.lane_idx);
         end
      end
      a.blk_valid = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (a.blk_ready === 1'b1) break;
      end
      repeat (3) @(negedge clk);
      checks++;
      if (a.lane_valid !== 1'b0 || a.busy !== 1'b0 || a.blk_ready !== 1'b1) begin
         errors++; $display("FAIL ignore_no_capture actual v=%0b busy=%0b rdy=%0b required 0 0 1", a.lane_valid, a.busy, a.blk_ready);
      end
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1;
      checks = 0; errors = 0;
      a.blk_in = '0; a.blk_valid = 1'b0; a.lane_ready = 1'b0;
      b.blk_in = '0; b.blk_valid = 1'b0; b.lane_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_zero_gap();
      test_ignore_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
